// File: rtl/flee_motion_controller_pkg.sv
// Shared types and constants for the fleeing-object motion path.
// Q20.12 signed fixed point throughout; screen bounds are reused by the renderer.
package flee_pkg;
    localparam int FRAC_BITS = 12;
    localparam int Q_WIDTH   = 32;

    typedef logic signed [Q_WIDTH-1:0] q_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        FLEE     = 2'b01,
        COOLDOWN = 2'b10
    } state_t;

    // HOLD leaves both velocity and position untouched
    typedef enum logic [1:0] {
        STEP_HOLD  = 2'b00,
        STEP_ACCEL = 2'b01,
        STEP_DECAY = 2'b10
    } step_t;

    typedef struct packed {
        q_t    vel;
        q_t    pos;
        step_t op;
        logic  neg;
    } axis_req_t;

    typedef struct packed {
        q_t vel;
        q_t pos;
    } axis_rsp_t;

    localparam q_t X_MAX = 32'h0027_F000;
    localparam q_t Y_MAX = 32'h001D_F000;
endpackage

// File: rtl/flee_motion_controller_if.sv
// Frame-rate handshake between the distance checker, this controller and the renderer.
interface flee_motion_if import flee_pkg::*; ();
    logic       frame_tick;
    logic       load;
    q_t         x_load;
    q_t         y_load;
    logic       is_close;
    logic       direction;
    q_t         x_pos;
    q_t         y_pos;
    q_t         x_vel;
    logic [1:0] state;
    logic       pos_update;

    modport master (
        output frame_tick, load, x_load, y_load, is_close, direction,
        input  x_pos, y_pos, x_vel, state, pos_update
    );

    modport slave (
        input  frame_tick, load, x_load, y_load, is_close, direction,
        output x_pos, y_pos, x_vel, state, pos_update
    );
endinterface

// File: rtl/flee_motion_controller_axis_integrator.sv
// Combinational one-axis step: saturated velocity update followed by a bounded position move.
// Hitting a bound pins the position there and kills the velocity.
module axis_integrator import flee_pkg::*; #(
    parameter q_t ACCEL     = 32'h0000_0400,
    parameter q_t DECEL     = 32'h0000_0200,
    parameter q_t MAX_SPEED = 32'h0000_4000,
    parameter q_t P_MIN     = 32'h0000_0000,
    parameter q_t P_MAX     = 32'h0027_F000
) (
    input  axis_req_t req,
    output axis_rsp_t rsp
);
    localparam logic signed [Q_WIDTH:0] ACC_W  = {ACCEL[Q_WIDTH-1], ACCEL};
    localparam logic signed [Q_WIDTH:0] DEC_W  = {DECEL[Q_WIDTH-1], DECEL};
    localparam logic signed [Q_WIDTH:0] MAX_W  = {MAX_SPEED[Q_WIDTH-1], MAX_SPEED};
    localparam logic signed [Q_WIDTH:0] PMIN_W = {P_MIN[Q_WIDTH-1], P_MIN};
    localparam logic signed [Q_WIDTH:0] PMAX_W = {P_MAX[Q_WIDTH-1], P_MAX};

    logic signed [Q_WIDTH:0] vel_w, pos_w, vsum, vnext, pnext;

    always_comb begin
        vel_w = {req.vel[Q_WIDTH-1], req.vel};
        pos_w = {req.pos[Q_WIDTH-1], req.pos};
        vsum  = vel_w;
        vnext = vel_w;
        unique case (req.op)
            STEP_ACCEL: begin
                vsum = req.neg ? (vel_w - ACC_W) : (vel_w + ACC_W);
                if (vsum > MAX_W)       vnext = MAX_W;
                else if (vsum < -MAX_W) vnext = -MAX_W;
                else                    vnext = vsum;
            end
            STEP_DECAY: begin
                // shrink magnitude toward zero, never past it, sign kept
                if (vel_w[Q_WIDTH]) begin
                    vsum  = vel_w + DEC_W;
                    vnext = (!vsum[Q_WIDTH] && (vsum != '0)) ? '0 : vsum;
                end else begin
                    vsum  = vel_w - DEC_W;
                    vnext = vsum[Q_WIDTH] ? '0 : vsum;
                end
            end
            default: vnext = vel_w;
        endcase

        pnext   = pos_w + vnext;
        rsp.vel = req.vel;
        rsp.pos = req.pos;
        if (req.op != STEP_HOLD) begin
            if (pnext < PMIN_W) begin
                rsp.pos = P_MIN;
                rsp.vel = '0;
            end else if (pnext > PMAX_W) begin
                rsp.pos = P_MAX;
                rsp.vel = '0;
            end else begin
                rsp.pos = pnext[Q_WIDTH-1:0];
                rsp.vel = vnext[Q_WIDTH-1:0];
            end
        end
    end
endmodule

// File: rtl/flee_motion_controller.sv
// Per-frame flee/cooldown FSM driving an x-axis integrator; y only moves on load.
// All state advances on frame_tick or load; load wins when both are high.
module flee_motion_controller import flee_pkg::*; #(
    parameter q_t ACCEL           = 32'h0000_0400,
    parameter q_t DECEL           = 32'h0000_0200,
    parameter q_t MAX_SPEED       = 32'h0000_4000,
    parameter int COOLDOWN_FRAMES = 30,
    parameter q_t X_MIN           = 32'h0000_0000,
    parameter q_t X_MAX           = 32'h0027_F000
) (
    input  logic          clk,
    input  logic          rst_n,
    flee_motion_if.slave  bus
);
    localparam int CNT_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    q_t               x_pos_q, y_pos_q, x_vel_q, x_load_clamped;
    logic             upd_q, step_en, vel_zero;
    axis_req_t        ax_req;
    axis_rsp_t        ax_rsp;

    axis_integrator #(
        .ACCEL(ACCEL), .DECEL(DECEL), .MAX_SPEED(MAX_SPEED),
        .P_MIN(X_MIN), .P_MAX(X_MAX)
    ) u_x_axis (
        .req(ax_req),
        .rsp(ax_rsp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.load) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (bus.frame_tick) begin
            unique case (state_q)
                IDLE: if (bus.is_close) state_d = FLEE;
                FLEE: if (!bus.is_close) begin
                    state_d = COOLDOWN;
                    cnt_d   = CNT_LOAD;
                end
                COOLDOWN: begin
                    if (bus.is_close) begin
                        state_d = FLEE;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Which integrator step this tick applies; the FSM edge that leaves a state
    // selects the step of the state being entered.
    always_comb begin
        step_en    = 1'b0;
        vel_zero   = 1'b0;
        ax_req.vel = x_vel_q;
        ax_req.pos = x_pos_q;
        ax_req.neg = bus.direction;
        ax_req.op  = STEP_HOLD;
        if (!bus.load && bus.frame_tick) begin
            unique case (state_q)
                IDLE: if (bus.is_close) begin
                    ax_req.op = STEP_ACCEL;
                    step_en   = 1'b1;
                end
                FLEE: begin
                    ax_req.op = bus.is_close ? STEP_ACCEL : STEP_DECAY;
                    step_en   = 1'b1;
                end
                COOLDOWN: begin
                    if (bus.is_close) begin
                        ax_req.op = STEP_ACCEL;
                        step_en   = 1'b1;
                    end else if (cnt_q == '0) begin
                        vel_zero = 1'b1;
                    end else begin
                        ax_req.op = STEP_DECAY;
                        step_en   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        x_load_clamped = bus.x_load;
        if (bus.x_load < X_MIN)      x_load_clamped = X_MIN;
        else if (bus.x_load > X_MAX) x_load_clamped = X_MAX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pos_q <= '0;
            y_pos_q <= '0;
            x_vel_q <= '0;
            upd_q   <= 1'b0;
        end else if (bus.load) begin
            x_pos_q <= x_load_clamped;
            y_pos_q <= bus.y_load;
            x_vel_q <= '0;
            upd_q   <= 1'b1;
        end else if (step_en) begin
            x_pos_q <= ax_rsp.pos;
            x_vel_q <= ax_rsp.vel;
            upd_q   <= 1'b1;
        end else if (vel_zero) begin
            x_vel_q <= '0;
            upd_q   <= 1'b1;
        end else begin
            upd_q   <= 1'b0;
        end
    end

    assign bus.x_pos      = x_pos_q;
    assign bus.y_pos      = y_pos_q;
    assign bus.x_vel      = x_vel_q;
    assign bus.state      = state_q;
    assign bus.pos_update = upd_q;
endmodule

// File: tb/tb_flee_motion_controller.sv
// Randomized + directed bench for flee_motion_controller with a queue-based scoreboard
// fed by an integer-arithmetic reference model of the motion rules.
module tb_flee_motion_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    flee_motion_if bus ();

    flee_motion_controller dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] v;
        logic [1:0]  st;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    localparam longint ACC  = 1024;
    localparam longint DEC  = 512;
    localparam longint VMAX = 16384;
    localparam longint XMIN = 0;
    localparam longint XMAX = 64'h27F000;
    localparam int     FRAMES = 30;

    // model: state 0 idle, 1 flee, 2 cooldown; m_el counts cooldown ticks after entry
    longint m_x, m_y, m_v;
    int     m_st, m_el;
    bit     m_upd;

    task automatic m_reset();
        m_x = 0; m_y = 0; m_v = 0; m_st = 0; m_el = 0;
    endtask

    task automatic m_move(input longint v);
        longint p;
        p = m_x + v;
        if (p < XMIN)      begin m_x = XMIN; m_v = 0; end
        else if (p > XMAX) begin m_x = XMAX; m_v = 0; end
        else               begin m_x = p;    m_v = v; end
    endtask

    task automatic m_flee(input bit dir);
        longint v;
        v = m_v + (dir ? -ACC : ACC);
        if (v > VMAX)  v = VMAX;
        if (v < -VMAX) v = -VMAX;
        m_move(v);
    endtask

    task automatic m_decay();
        longint mag;
        mag = (m_v < 0 ? -m_v : m_v) - DEC;
        if (mag < 0) mag = 0;
        m_move(m_v < 0 ? -mag : mag);
    endtask

    task automatic m_tick(input bit close, input bit dir);
        m_upd = 1'b1;
        case (m_st)
            0: if (close) begin m_st = 1; m_flee(dir); end else m_upd = 1'b0;
            1: if (close) m_flee(dir);
               else begin m_st = 2; m_el = 0; m_decay(); end
            default: if (close) begin m_st = 1; m_flee(dir); end
               else begin
                   m_el++;
                   if (m_el >= FRAMES) begin m_st = 0; m_v = 0; end
                   else m_decay();
               end
        endcase
    endtask

    task automatic push_exp();
        exp_t e;
        e.x = m_x[31:0]; e.y = m_y[31:0]; e.v = m_v[31:0]; e.st = m_st[1:0];
        exp_q.push_back(e);
    endtask

    // drive one cycle of stimulus, record its expected outcome, drop the strobes
    task automatic issue(input bit tick, input bit ld, input bit close, input bit dir,
                         input logic [31:0] xl, input logic [31:0] yl);
        longint lx;
        bus.frame_tick = tick; bus.load = ld; bus.is_close = close;
        bus.direction = dir; bus.x_load = xl; bus.y_load = yl;
        if (ld) begin
            lx = longint'($signed(xl));
            m_x = (lx < XMIN) ? XMIN : (lx > XMAX) ? XMAX : lx;
            m_y = longint'($signed(yl));
            m_v = 0; m_st = 0; m_el = 0;
            push_exp();
        end else if (tick) begin
            m_tick(close, dir);
            if (m_upd) push_exp();
        end
        @(posedge clk); #1;
        bus.frame_tick = 1'b0; bus.load = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    initial begin : mon
        exp_t e, last;
        last = '{x: 0, y: 0, v: 0, st: 0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last = '{x: 0, y: 0, v: 0, st: 0};
                checks++;
                if ({bus.x_pos, bus.y_pos, bus.x_vel, bus.state, bus.pos_update} !== 99'd0) begin
                    failures++;
                    $display("FAIL reset_state: x=%h y=%h v=%h st=%0d upd=%b expected all zero",
                             bus.x_pos, bus.y_pos, bus.x_vel, bus.state, bus.pos_update);
                end
            end else if (bus.pos_update) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_update: pos_update=1 expected 0");
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.x_pos, bus.y_pos, bus.x_vel, bus.state} !== {e.x, e.y, e.v, e.st}) begin
                        failures++;
                        $display("FAIL update: got x=%h y=%h v=%h st=%0d expected x=%h y=%h v=%h st=%0d",
                                 bus.x_pos, bus.y_pos, bus.x_vel, bus.state, e.x, e.y, e.v, e.st);
                    end
                    last = e;
                end
            end else begin
                checks++;
                if ({bus.x_pos, bus.y_pos, bus.x_vel, bus.state} !== {last.x, last.y, last.v, last.st}) begin
                    failures++;
                    $display("FAIL hold: got x=%h y=%h v=%h st=%0d expected x=%h y=%h v=%h st=%0d",
                             bus.x_pos, bus.y_pos, bus.x_vel, bus.state, last.x, last.y, last.v, last.st);
                end
            end
        end
    end

    initial begin : stim
        bit          cl, dr;
        int          len;
        logic [31:0] xr;
        bus.frame_tick = 0; bus.load = 0; bus.is_close = 0; bus.direction = 0;
        bus.x_load = 0; bus.y_load = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // load, then accelerate to the speed ceiling
        issue(0, 1, 0, 0, 32'h0006_4000, 32'h0003_2000);
        chk("load_x", bus.x_pos, 32'h0006_4000);
        chk("load_y", bus.y_pos, 32'h0003_2000);
        @(posedge clk); #1;
        issue(1, 0, 1, 0, 0, 0);
        chk("flee1_vel", bus.x_vel, 32'h0000_0400);
        chk("flee1_pos", bus.x_pos, 32'h0006_4400);
        chk("flee1_state", 32'(bus.state), 32'd1);
        for (int i = 2; i <= 17; i++) begin
            issue(1, 0, 1, 0, 0, 0);
            if (i == 16) chk("flee16_vel", bus.x_vel, 32'h0000_4000);
        end
        chk("flee17_vel", bus.x_vel, 32'h0000_4000);

        // cooldown decay and expiry
        for (int i = 1; i <= 33; i++) begin
            issue(1, 0, 0, 0, 0, 0);
            if (i == 1)  chk("cool1_vel", bus.x_vel, 32'h0000_3E00);
            if (i == 1)  chk("cool1_state", 32'(bus.state), 32'd2);
            if (i == 30) chk("cool30_state", 32'(bus.state), 32'd2);
            if (i == 31) chk("cool31_state", 32'(bus.state), 32'd0);
            if (i == 31) chk("cool31_vel", bus.x_vel, 32'h0);
        end

        // right bound
        issue(0, 1, 0, 0, 32'h0027_5000, 32'h0000_1000);
        for (int i = 0; i < 8; i++) issue(1, 0, 1, 0, 0, 0);
        chk("rb_pre_pos", bus.x_pos, 32'h0027_E000);
        chk("rb_pre_vel", bus.x_vel, 32'h0000_2000);
        issue(1, 0, 1, 0, 0, 0);
        chk("rb_pos", bus.x_pos, 32'h0027_F000);
        chk("rb_vel", bus.x_vel, 32'h0);
        chk("rb_state", 32'(bus.state), 32'd1);

        // left bound
        issue(0, 1, 0, 0, 32'h0000_B000, 32'h0000_2000);
        for (int i = 0; i < 8; i++) issue(1, 0, 1, 1, 0, 0);
        chk("lb_pre_pos", bus.x_pos, 32'h0000_2000);
        issue(1, 0, 1, 1, 0, 0);
        chk("lb_pos", bus.x_pos, 32'h0);
        chk("lb_vel", bus.x_vel, 32'h0);
        chk("lb_state", 32'(bus.state), 32'd1);

        // load beats a simultaneous tick during flee
        for (int i = 0; i < 3; i++) issue(1, 0, 1, 0, 0, 0);
        issue(1, 1, 1, 0, 32'h0010_0000, 32'h0005_0000);
        chk("ldtick_x", bus.x_pos, 32'h0010_0000);
        chk("ldtick_vel", bus.x_vel, 32'h0);
        chk("ldtick_state", 32'(bus.state), 32'd0);

        // async reset between edges mid-flee
        for (int i = 0; i < 4; i++) issue(1, 0, 1, 0, 0, 0);
        #2 rst_n = 1'b0;
        exp_q.delete();
        m_reset();
        #1;
        chk("arst_x", bus.x_pos, 32'h0);
        chk("arst_y", bus.y_pos, 32'h0);
        chk("arst_vel", bus.x_vel, 32'h0);
        chk("arst_state", 32'(bus.state), 32'd0);
        chk("arst_upd", 32'(bus.pos_update), 32'd0);
        @(posedge clk); #1 bus.frame_tick = 1'b1;
        @(posedge clk); #1 bus.frame_tick = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // randomized segments with is_close held per segment
        for (int s = 0; s < 50; s++) begin
            cl  = 1'($urandom_range(0, 1));
            dr  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 45);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) dr = ~dr;
                if ($urandom_range(0, 59) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       xr = $urandom_range(0, 32'h0027_F000);
                        1:       xr = $urandom;
                        default: xr = 32'h0027_F000 - $urandom_range(0, 32'h8000);
                    endcase
                    issue(1'($urandom_range(0, 1)), 1, cl, dr, xr, $urandom);
                end else begin
                    issue($urandom_range(0, 3) != 0, 0, cl, dr, 0, 0);
                end
            end
        end

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d updates outstanding, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
